// File: rtl/ooo_pkg.sv
// Shared types and helpers for the out-of-order core: default widths,
// the reorder-buffer entry layout and the pointer-width helper.
package ooo_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  typedef struct packed {
    logic              valid;
    logic              finished;
    logic [REG_W-1:0]  target;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Finds the run of consecutive valid+finished entries starting at the commit
// pointer, capped at COMMIT_W, and emits per-lane enables and indices.
module rob_commit_select
  import ooo_pkg::*;
#(
  parameter  int DEPTH    = 16,
  parameter  int COMMIT_W = 4,
  localparam int PTR_W    = ptr_w(DEPTH),
  localparam int K_W      = $clog2(COMMIT_W + 1)
) (
  input  logic [PTR_W-1:0]                commit_ptr_i,
  input  logic [DEPTH-1:0]                valid_i,
  input  logic [DEPTH-1:0]                finished_i,
  output logic [K_W-1:0]                  k_o,
  output logic [COMMIT_W-1:0]             lane_we_o,
  output logic [COMMIT_W-1:0][PTR_W-1:0]  lane_idx_o
);

  logic run_s;

  // Once an entry is not ready every younger lane is blocked.
  always_comb begin
    run_s      = 1'b1;
    k_o        = '0;
    lane_we_o  = '0;
    lane_idx_o = '0;
    for (int l = 0; l < COMMIT_W; l++) begin
      lane_idx_o[l] = commit_ptr_i + PTR_W'(l);
      if (run_s && valid_i[lane_idx_o[l]] && finished_i[lane_idx_o[l]]) begin
        lane_we_o[l] = 1'b1;
        k_o          = k_o + 1'b1;
      end else begin
        run_s = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Parametrised reorder buffer: in-order allocate, CDB writeback, in-order commit.
// Optional mispredict flush is enabled by defining REORDER_BUFFER_FLUSH_EN.
module reorder_buffer
  import ooo_pkg::*;
#(
  parameter  int DEPTH      = 16,
  parameter  int DISPATCH_W = 4,
  parameter  int CDB_W      = 4,
  parameter  int COMMIT_W   = 4,
  parameter  int DATA_W     = ooo_pkg::DATA_W,
  parameter  int REG_W      = ooo_pkg::REG_W,
  localparam int PTR_W      = ooo_pkg::ptr_w(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DISPATCH_W-1:0]                disp_valid,
  input  logic [DISPATCH_W-1:0][REG_W-1:0]     disp_target,
  output logic                                 disp_ready,
  output logic [DISPATCH_W-1:0][PTR_W-1:0]     disp_idx,
  input  logic [CDB_W-1:0]                     cdb_valid,
  input  logic [CDB_W-1:0][PTR_W-1:0]          cdb_idx,
  input  logic [CDB_W-1:0][DATA_W-1:0]         cdb_data,
  input  logic                                 flush_valid,
  input  logic [PTR_W-1:0]                     flush_idx,
  output logic [DEPTH-1:0]                     out_finished,
  output logic [DEPTH-1:0][DATA_W-1:0]         out_values,
  output logic [COMMIT_W-1:0]                  commit_we,
  output logic [COMMIT_W-1:0][REG_W-1:0]       commit_target,
  output logic [COMMIT_W-1:0][DATA_W-1:0]      commit_data,
  output logic [COMMIT_W-1:0][PTR_W-1:0]       commit_idx,
  output logic [PTR_W:0]                       count,
  output logic [PTR_W-1:0]                     alloc_ptr,
  output logic                                 empty,
  output logic                                 full
);

  localparam int K_W = $clog2(COMMIT_W + 1);

  typedef struct packed {
    logic              valid;
    logic              finished;
    logic [REG_W-1:0]  target;
    logic [DATA_W-1:0] value;
  } entry_t;

  entry_t                            rob_q [DEPTH];
  entry_t                            rob_d [DEPTH];
  logic [PTR_W-1:0]                  alloc_q, alloc_d, commit_q, commit_d;
  logic [PTR_W:0]                    count_q, count_d;
  logic [COMMIT_W-1:0]               commit_we_q, commit_we_d;
  logic [COMMIT_W-1:0][REG_W-1:0]    commit_target_q, commit_target_d;
  logic [COMMIT_W-1:0][DATA_W-1:0]   commit_data_q, commit_data_d;
  logic [COMMIT_W-1:0][PTR_W-1:0]    commit_idx_q, commit_idx_d;

  logic [PTR_W:0]                    free_s, n_valid_s, n_acc_s;
  logic [PTR_W-1:0]                  alloc_end_s;
  logic                              flush_act_s, dispatch_ok_s;
  logic [DEPTH-1:0]                  valid_s, fin_s;
  logic [K_W-1:0]                    k_s;
  logic [COMMIT_W-1:0]               lane_we_s;
  logic [COMMIT_W-1:0][PTR_W-1:0]    lane_idx_s;

`ifdef REORDER_BUFFER_FLUSH_EN
  assign flush_act_s = flush_valid;
`else
  logic unused_flush_s;
  assign unused_flush_s = ^{flush_valid, flush_idx};
  assign flush_act_s    = 1'b0;
`endif

  assign free_s        = (PTR_W+1)'(DEPTH) - count_q;
  assign disp_ready    = (32'(free_s) >= 32'(DISPATCH_W));
  assign dispatch_ok_s = disp_ready && !flush_act_s;
  assign n_acc_s       = dispatch_ok_s ? n_valid_s : '0;
  assign count         = count_q;
  assign alloc_ptr     = alloc_q;
  assign empty         = (count_q == '0);
  assign full          = (count_q == (PTR_W+1)'(DEPTH));
  assign commit_we     = commit_we_q;
  assign commit_target = commit_target_q;
  assign commit_data   = commit_data_q;
  assign commit_idx    = commit_idx_q;

  // Flatten per-entry flags for forwarding and for the commit selector.
  always_comb begin
    valid_s      = '0;
    fin_s        = '0;
    out_finished = '0;
    out_values   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      valid_s[j]      = rob_q[j].valid;
      fin_s[j]        = rob_q[j].finished;
      out_finished[j] = rob_q[j].finished;
      out_values[j]   = rob_q[j].value;
    end
  end

  // Sparse lanes pack densely: each valid lane takes the next free slot.
  always_comb begin
    alloc_end_s = alloc_q;
    n_valid_s   = '0;
    disp_idx    = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      disp_idx[i] = alloc_end_s;
      if (disp_valid[i]) begin
        alloc_end_s = alloc_end_s + 1'b1;
        n_valid_s   = n_valid_s + 1'b1;
      end else begin
        alloc_end_s = alloc_end_s;
      end
    end
  end

  rob_commit_select #(
    .DEPTH    (DEPTH),
    .COMMIT_W (COMMIT_W)
  ) u_commit_select (
    .commit_ptr_i (commit_q),
    .valid_i      (valid_s),
    .finished_i   (fin_s),
    .k_o          (k_s),
    .lane_we_o    (lane_we_s),
    .lane_idx_o   (lane_idx_s)
  );

  // Next state: CDB writes, then commit clears, then allocation, then flush.
  always_comb begin
    rob_d           = rob_q;
    commit_we_d     = lane_we_s;
    commit_target_d = '0;
    commit_data_d   = '0;
    commit_idx_d    = '0;
    commit_d        = commit_q + PTR_W'(k_s);
    alloc_d         = dispatch_ok_s ? alloc_end_s : alloc_q;
    count_d         = count_q + n_acc_s - (PTR_W+1)'(k_s);

    for (int c = 0; c < CDB_W; c++) begin
      if (cdb_valid[c] && rob_q[cdb_idx[c]].valid) begin
        rob_d[cdb_idx[c]].finished = 1'b1;
        rob_d[cdb_idx[c]].value    = cdb_data[c];
      end else begin
        rob_d[cdb_idx[c]] = rob_d[cdb_idx[c]];
      end
    end

    for (int l = 0; l < COMMIT_W; l++) begin
      if (lane_we_s[l]) begin
        commit_target_d[l]   = rob_q[lane_idx_s[l]].target;
        commit_data_d[l]     = rob_q[lane_idx_s[l]].value;
        commit_idx_d[l]      = lane_idx_s[l];
        rob_d[lane_idx_s[l]] = '0;
      end else begin
        commit_idx_d[l] = '0;
      end
    end

    for (int i = 0; i < DISPATCH_W; i++) begin
      if (dispatch_ok_s && disp_valid[i]) begin
        rob_d[disp_idx[i]] = '{1'b1, 1'b0, disp_target[i], {DATA_W{1'b0}}};
      end else begin
        rob_d[disp_idx[i]] = rob_d[disp_idx[i]];
      end
    end

`ifdef REORDER_BUFFER_FLUSH_EN
    // Age is measured from the pre-commit head so the ring order is unambiguous.
    if (flush_valid) begin
      logic [PTR_W-1:0] f_age, age, rem;
      f_age = flush_idx - commit_q;
      for (int j = 0; j < DEPTH; j++) begin
        age = PTR_W'(j) - commit_q;
        if (age > f_age) begin
          rob_d[j] = '0;
        end else begin
          rob_d[j] = rob_d[j];
        end
      end
      alloc_d = flush_idx + 1'b1;
      rem     = flush_idx + 1'b1 - commit_d;
      if (32'(f_age) < 32'(k_s)) begin
        count_d = '0;
      end else if (rem != '0) begin
        count_d = {1'b0, rem};
      end else begin
        count_d = count_d;
      end
    end else begin
      alloc_d = alloc_d;
    end
`endif
  end

  // State and registered commit outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q         <= '0;
      commit_q        <= '0;
      count_q         <= '0;
      commit_we_q     <= '0;
      commit_target_q <= '0;
      commit_data_q   <= '0;
      commit_idx_q    <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        rob_q[j] <= '0;
      end
    end else begin
      alloc_q         <= alloc_d;
      commit_q        <= commit_d;
      count_q         <= count_d;
      commit_we_q     <= commit_we_d;
      commit_target_q <= commit_target_d;
      commit_data_q   <= commit_data_d;
      commit_idx_q    <= commit_idx_d;
      for (int j = 0; j < DEPTH; j++) begin
        rob_q[j] <= rob_d[j];
      end
    end
  end

endmodule
